// File: rtl/tone_scheduler.sv
// Shares one tone oscillator among four requesters with round-robin arbitration and a silent gap between tones.
// Optional macro TONE_SCHEDULER_PREEMPT_EN: requester 0 preempts any other tone in PLAY or GAP.
module tone_scheduler #(
    parameter int DUR_CYCLES = 10000000,
    parameter int GAP_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        nRst,
    input  logic        state,
    input  logic [3:0]  req,
    input  logic [31:0] req_freq,
    output logic [7:0]  freq,
    output logic        playSound,
    output logic [3:0]  grant,
    output logic        busy
);
    // state | meaning
    // IDLE  | no tone, waiting for a pending request while ON
    // START | playSound strobe cycle, grant and freq just loaded
    // PLAY  | tone held for DUR_CYCLES
    // GAP   | silence for GAP_CYCLES, grant released, freq held
    localparam logic [1:0]  IDLE     = 2'd0;
    localparam logic [1:0]  START    = 2'd1;
    localparam logic [1:0]  PLAY     = 2'd2;
    localparam logic [1:0]  GAP      = 2'd3;
    localparam logic        MODE_ON  = 1'b1;
    localparam logic [23:0] DUR_LAST = 24'(DUR_CYCLES - 1);
    localparam logic [23:0] GAP_LAST = 24'(GAP_CYCLES - 1);

    logic [1:0]  fsm, fsm_nxt;
    logic [3:0]  pending;
    logic [23:0] cnt, cnt_nxt;
    logic [1:0]  last_id;
    logic [1:0]  rr_id;
    logic        rr_hit;
    logic        take;
    logic [1:0]  win_id;
    logic [3:0]  clr_mask;

    always_comb begin
        rr_id  = 2'd0;
        rr_hit = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!rr_hit && pending[last_id + 2'(k)]) begin
                rr_hit = 1'b1;
                rr_id  = last_id + 2'(k);
            end
        end
    end

    // A request already pending at the last GAP cycle starts straight away, so
    // back-to-back tones repeat every 1 + DUR_CYCLES + GAP_CYCLES cycles.
    always_comb begin
        fsm_nxt = fsm;
        cnt_nxt = cnt;
        take    = 1'b0;
        win_id  = rr_id;
        case (fsm)
            IDLE: begin
                if (rr_hit) take = 1'b1;
            end
            START: begin
                fsm_nxt = PLAY;
                cnt_nxt = '0;
            end
            PLAY: begin
                if (cnt == DUR_LAST) begin
                    fsm_nxt = GAP;
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 24'd1;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_nxt = '0;
                    if (rr_hit) take = 1'b1;
                    else        fsm_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 24'd1;
                end
            end
            default: fsm_nxt = IDLE;
        endcase
`ifdef TONE_SCHEDULER_PREEMPT_EN
        if ((fsm == PLAY || fsm == GAP) && pending[0] && last_id != 2'd0) begin
            take   = 1'b1;
            win_id = 2'd0;
        end
`endif
        if (take) begin
            fsm_nxt = START;
            cnt_nxt = '0;
        end
    end

    assign clr_mask = take ? (4'b0001 << win_id) : 4'b0000;

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            fsm       <= IDLE;
            pending   <= '0;
            cnt       <= '0;
            last_id   <= 2'd3;
            freq      <= '0;
            playSound <= 1'b0;
            grant     <= '0;
        end else if (state != MODE_ON) begin
            fsm       <= IDLE;
            pending   <= '0;
            cnt       <= '0;
            freq      <= '0;
            playSound <= 1'b0;
            grant     <= '0;
        end else begin
            fsm       <= fsm_nxt;
            cnt       <= cnt_nxt;
            // a request arriving on the clearing edge wins, so the winner retriggers
            pending   <= (pending & ~clr_mask) | req;
            playSound <= take;
            if (take) begin
                freq    <= req_freq[{win_id, 3'b000} +: 8];
                grant   <= 4'b0001 << win_id;
                last_id <= win_id;
            end else if (fsm_nxt != PLAY) begin
                grant   <= '0;
            end
        end
    end

    assign busy = (fsm != IDLE);

endmodule

// File: tb/tb_tone_scheduler.sv
// Self-checking bench for tone_scheduler (DUR_CYCLES=20, GAP_CYCLES=4) against a time-based tone model.
module tb_tone_scheduler;
    localparam int DUR = 20;
    localparam int GAP = 4;

    logic        clk;
    logic        nRst;
    logic        mode;
    logic [3:0]  req;
    logic [31:0] req_freq;
    logic [7:0]  freq;
    logic        playSound;
    logic [3:0]  grant;
    logic        busy;

    tone_scheduler #(.DUR_CYCLES(DUR), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .nRst(nRst), .state(mode), .req(req), .req_freq(req_freq),
        .freq(freq), .playSound(playSound), .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a tone is a START cycle at elapsed time 0, PLAY at 1..DUR, GAP at DUR+1..DUR+GAP.
    bit         m_act;
    int         m_t;
    int         m_own;
    int         m_last;
    logic [3:0] m_pend;
    logic [7:0] m_freq;

    always @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            m_act = 0; m_t = 0; m_own = 0; m_last = 3; m_pend = '0; m_freq = '0;
        end else if (!mode) begin
            m_act = 0; m_t = 0; m_pend = '0; m_freq = '0;
        end else begin
            bit go;
            bit found;
            int w;
            go = 0; found = 0; w = 0;
            if (m_pend != 4'b0000 && (!m_act || m_t == DUR + GAP)) begin
                go = 1;
                for (int k = 1; k <= 4; k++) begin
                    if (!found && m_pend[(m_last + k) % 4]) begin
                        found = 1;
                        w = (m_last + k) % 4;
                    end
                end
            end
`ifdef TONE_SCHEDULER_PREEMPT_EN
            if (m_act && m_t >= 1 && m_pend[0] && m_own != 0) begin
                go = 1;
                w = 0;
            end
`endif
            if (go) begin
                m_pend[w] = 1'b0;
                m_act = 1; m_t = 0; m_own = w; m_last = w;
                m_freq = req_freq[w*8 +: 8];
            end else if (m_act) begin
                m_t++;
                if (m_t > DUR + GAP) m_act = 0;
            end
            m_pend = m_pend | req;
        end
    end

    logic [7:0] e_freq;
    logic       e_play;
    logic [3:0] e_grant;
    logic       e_busy;
    assign e_freq  = m_freq;
    assign e_play  = m_act && (m_t == 0);
    assign e_grant = (m_act && m_t <= DUR) ? (4'b0001 << m_own) : 4'b0000;
    assign e_busy  = m_act;

    always @(negedge clk) begin
        if (nRst && chk_en) begin
            check("cmp_freq", {24'd0, freq}, {24'd0, e_freq});
            check("cmp_playSound", {31'd0, playSound}, {31'd0, e_play});
            check("cmp_grant", {28'd0, grant}, {28'd0, e_grant});
            check("cmp_busy", {31'd0, busy}, {31'd0, e_busy});
        end
    end

    task automatic pulse_req(input logic [3:0] m, output int t0);
        @(negedge clk);
        t0  = cyc;
        req = m;
        @(negedge clk);
        req = 4'b0000;
    endtask

    task automatic wait_play(input string name, input int budget, output int c);
        int i;
        c = -1;
        i = 0;
        while (c < 0 && i < budget) begin
            @(negedge clk);
            if (playSound === 1'b1) c = cyc;
            i++;
        end
        if (c < 0) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic count_plays(input int ncyc, output int n);
        n = 0;
        repeat (ncyc) begin
            @(negedge clk);
            if (playSound === 1'b1) n++;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_freq"}, {24'd0, freq}, 32'd0);
        check({name, "_play"}, {31'd0, playSound}, 32'd0);
        check({name, "_grant"}, {28'd0, grant}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, c, c1, c2, n, m;
        int cs[4];
        logic [3:0] gexp[4];
        logic [7:0] fexp[4];
        gexp[0] = 4'b0001; gexp[1] = 4'b0010; gexp[2] = 4'b0100; gexp[3] = 4'b1000;
        fexp[0] = 8'h40;   fexp[1] = 8'h51;   fexp[2] = 8'h62;   fexp[3] = 8'h83;

        nRst = 1'b0; mode = 1'b1; req = 4'b0000; req_freq = 32'h8362_5140;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        nRst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);

        // single request
        pulse_req(4'b0001, t0);
        wait_play("single", 20, c);
        check("single_latency", 32'(c - t0), 32'd2);
        check("single_freq", {24'd0, freq}, 32'h40);
        n = 0;
        while (grant === 4'b0001 && n < 100) begin n++; @(negedge clk); end
        check("single_grant_len", 32'(n), 32'd21);
        m = 0;
        while (busy === 1'b1 && m < 100) begin m++; @(negedge clk); end
        check("single_gap_len", 32'(m), 32'd4);

        // round robin from a fresh last_id
        @(negedge clk); nRst = 1'b0;
        @(negedge clk); nRst = 1'b1;
        pulse_req(4'b1111, t0);
        for (int i = 0; i < 4; i++) begin
            wait_play("rr", 40, cs[i]);
            check("rr_grant", {28'd0, grant}, {28'd0, gexp[i]});
            check("rr_freq", {24'd0, freq}, {24'd0, fexp[i]});
            if (i == 0) check("rr_latency", 32'(cs[0] - t0), 32'd2);
            else        check("rr_period", 32'(cs[i] - cs[i-1]), 32'd25);
        end
        count_plays(40, n);
        check("rr_no_extra", 32'(n), 32'd0);

        // retrigger: req[2] held across its START edge
        @(negedge clk);
        t0 = cyc;
        req = 4'b0100;
        @(negedge clk);
        @(negedge clk);
        req = 4'b0000;
        check("retrig_play1", {31'd0, playSound}, 32'd1);
        check("retrig_grant1", {28'd0, grant}, 32'h4);
        check("retrig_latency", 32'(cyc - t0), 32'd2);
        wait_play("retrig", 40, c);
        check("retrig_period", 32'(c - (t0 + 2)), 32'd25);
        check("retrig_grant2", {28'd0, grant}, 32'h4);
        count_plays(40, n);
        check("retrig_no_third", 32'(n), 32'd0);

        // mode abort at PLAY cycle 10, req ignored while OFF
        pulse_req(4'b0010, t0);
        wait_play("abort", 20, c);
        check("abort_grant", {28'd0, grant}, 32'h2);
        repeat (10) @(negedge clk);
        mode = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_grant0", {28'd0, grant}, 32'd0);
        check("abort_freq0", {24'd0, freq}, 32'd0);
        req = 4'b1000;
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        mode = 1'b1;
        count_plays(40, n);
        check("abort_no_replay", 32'(n), 32'd0);

        // reset mid-play with pending=1010
        pulse_req(4'b1000, t0);
        wait_play("rst", 20, c);
        check("rst_grant", {28'd0, grant}, 32'h8);
        @(negedge clk);
        pulse_req(4'b1010, t0);
        repeat (2) @(negedge clk);
        #2 nRst = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge clk);
        nRst = 1'b1;
        count_plays(60, n);
        check("rst_no_tone", 32'(n), 32'd0);

        // requester 0 arriving during requester 3's PLAY cycle 8
        pulse_req(4'b1000, t0);
        wait_play("pre", 20, c1);
        check("pre_grant3", {28'd0, grant}, 32'h8);
        repeat (7) @(negedge clk);
        pulse_req(4'b0001, t0);
        check("pre_req_cycle", 32'(t0 - c1), 32'd8);
        wait_play("pre", 60, c2);
        check("pre_grant0", {28'd0, grant}, 32'h1);
        check("pre_freq0", {24'd0, freq}, 32'h40);
`ifdef TONE_SCHEDULER_PREEMPT_EN
        check("pre_start_delay", 32'(c2 - c1), 32'd10);
`else
        check("pre_start_delay", 32'(c2 - c1), 32'd25);
`endif
        count_plays(40, n);
        check("pre_no_extra", 32'(n), 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
